// File: rtl/shift_reg_8bit_pkg.sv
// rtl/shift_reg_8bit_pkg.sv - shared constants and types for the SIPO shift register
//
// Purpose : default width, default reset word and the data-word typedef used
//           by shift_reg_8bit and anything that talks to it at its default size.
// Ports   : none (package).
package shift_reg_8bit_pkg;

    localparam int SHREG_DEFAULT_WIDTH = 8;

    typedef logic [SHREG_DEFAULT_WIDTH-1:0] shreg_word_t;

    localparam shreg_word_t SHREG_DEFAULT_RESET = '0;

endpackage

// File: rtl/shift_reg_8bit_dff_ar.sv
// rtl/shift_reg_8bit_dff_ar.sv - 1-bit flop with asynchronous active-low reset
//
// Purpose : single storage stage of the shift register.
// Ports   : i_clk   - rising-edge clock
//           i_rst_n - asynchronous active-low reset, loads RESET_VAL
//           i_d     - data sampled on the rising edge
//           o_q     - flop output
module dff_ar #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/shift_reg_8bit.sv
// rtl/shift_reg_8bit.sv - serial-in parallel-out shift register
//
// Purpose : shifts SER in on every rising Clk edge; all stages visible on Q.
// Ports   : Clk - rising-edge clock
//           RST - asynchronous active-low reset, forces Q to RESET_VALUE
//           SER - serial data in
//           Q   - parallel contents, straight from the flops
module shift_reg_8bit
    import shift_reg_8bit_pkg::*;
#(
    parameter int               WIDTH        = SHREG_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter bit               MSB_FIRST_IN = 1'b0
) (
    input  logic             Clk,
    input  logic             RST,
    input  logic             SER,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_q;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_stage
            // Entry stage takes SER; every other stage takes its upstream neighbour.
            if (MSB_FIRST_IN) begin : g_msb_in
                if (i == WIDTH-1) begin : g_entry
                    assign w_d[i] = SER;
                end else begin : g_chain
                    assign w_d[i] = w_q[i+1];
                end
            end else begin : g_lsb_in
                if (i == 0) begin : g_entry
                    assign w_d[i] = SER;
                end else begin : g_chain
                    assign w_d[i] = w_q[i-1];
                end
            end

            dff_ar #(
                .RESET_VAL (RESET_VALUE[i])
            ) u_dff (
                .i_clk   (Clk),
                .i_rst_n (RST),
                .i_d     (w_d[i]),
                .o_q     (w_q[i])
            );
        end
    endgenerate

    assign Q = w_q;

endmodule

// File: tb/tb_shift_reg_8bit.sv
// tb/tb_shift_reg_8bit.sv - directed self-checking bench for shift_reg_8bit
module tb_shift_reg_8bit;
    import shift_reg_8bit_pkg::*;

    logic        Clk;
    logic        RST;
    logic        SER;
    shreg_word_t Q;

    logic        RST4;
    logic        SER4;
    logic [3:0]  Q4;

    int n_cmp;
    int n_fail;

    shift_reg_8bit u_dut (
        .Clk (Clk),
        .RST (RST),
        .SER (SER),
        .Q   (Q)
    );

    shift_reg_8bit #(
        .WIDTH        (4),
        .RESET_VALUE  (4'h0),
        .MSB_FIRST_IN (1'b1)
    ) u_dut4 (
        .Clk (Clk),
        .RST (RST4),
        .SER (SER4),
        .Q   (Q4)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    task automatic test_reset();
        RST = 1'b0;
        SER = 1'b1;
        #1;
        n_cmp++;
        if (Q !== SHREG_DEFAULT_RESET) begin
            n_fail++;
            $display("FAIL reset_initial: got %h expected %h", Q, SHREG_DEFAULT_RESET);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            n_cmp++;
            if (Q !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_held[%0d]: got %h expected 00", k, Q);
            end
        end
    endtask

    task automatic test_fill_ones();
        logic [7:0] exp_q [10] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F,
                                   8'h3F, 8'h7F, 8'hFF, 8'hFF, 8'hFF};
        @(negedge Clk);
        RST = 1'b1;
        SER = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            n_cmp++;
            if (Q !== exp_q[k]) begin
                n_fail++;
                $display("FAIL fill_ones[edge %0d]: got %h expected %h", k+1, Q, exp_q[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        // Q is FF here; assert reset well away from any rising edge.
        #3;
        RST = 1'b0;
        #1;
        n_cmp++;
        if (Q !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset_immediate: got %h expected 00", Q);
        end
        #2;
        RST = 1'b1;
        SER = 1'b1;
        #1;
        n_cmp++;
        if (Q !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset_release_no_edge: got %h expected 00", Q);
        end
        @(negedge Clk);
        n_cmp++;
        if (Q !== 8'h01) begin
            n_fail++;
            $display("FAIL async_reset_first_shift: got %h expected 01", Q);
        end
    endtask

    task automatic test_pattern();
        logic       ser_v [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                                   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] exp_q [10] = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16,
                                   8'h2C, 8'h59, 8'hB2, 8'h64, 8'hC8};
        RST = 1'b0;
        #1;
        RST = 1'b1;
        for (int k = 0; k < 10; k++) begin
            SER = ser_v[k];
            @(negedge Clk);
            n_cmp++;
            if (Q !== exp_q[k]) begin
                n_fail++;
                $display("FAIL pattern[edge %0d]: got %h expected %h", k+1, Q, exp_q[k]);
            end
        end
    endtask

    task automatic test_release_on_edge();
        RST = 1'b0;
        SER = 1'b1;
        @(posedge Clk);
        // Release lands inside the hold window of this edge, so the edge saw reset.
        #1;
        RST = 1'b1;
        @(negedge Clk);
        n_cmp++;
        if (Q !== 8'h00) begin
            n_fail++;
            $display("FAIL release_edge_no_shift: got %h expected 00", Q);
        end
        @(negedge Clk);
        n_cmp++;
        if (Q !== 8'h01) begin
            n_fail++;
            $display("FAIL release_edge_next_shift: got %h expected 01", Q);
        end
    endtask

    task automatic test_msb_first_w4();
        logic       ser_v [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [3:0] exp_q [5] = '{4'h8, 4'h4, 4'h2, 4'h1, 4'h0};
        n_cmp++;
        if (Q4 !== 4'h0) begin
            n_fail++;
            $display("FAIL w4_reset: got %h expected 0", Q4);
        end
        RST4 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            SER4 = ser_v[k];
            @(negedge Clk);
            n_cmp++;
            if (Q4 !== exp_q[k]) begin
                n_fail++;
                $display("FAIL w4_msb_first[edge %0d]: got %h expected %h", k+1, Q4, exp_q[k]);
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        RST4   = 1'b0;
        SER4   = 1'b1;
        test_reset();
        test_fill_ones();
        test_async_reset();
        test_pattern();
        test_release_on_edge();
        @(negedge Clk);
        test_msb_first_w4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_reg_8bit.md
Name: shift_reg_8bit

Overview:
- Serial-in, parallel-out (SIPO) shift register; default width 8.
- Each rising clock edge shifts one serial bit in at the LSB; all stored bits are visible in parallel on Q.
- Leaf datapath block used for serial-to-parallel capture. No handshake and no enable: it shifts on every clock edge while out of reset.

Parameters:
- WIDTH, 8, number of stages and width of Q; legal range 2 or more.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into Q while reset is asserted.
- MSB_FIRST_IN, 0:
  - 0: SER enters Q[0] and data moves toward Q[WIDTH-1].
  - 1: SER enters Q[WIDTH-1] and data moves toward Q[0].

Ports:
- Clk  input  1  single clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset. 0 forces Q to RESET_VALUE immediately. Release is sampled at the next rising Clk.
- SER  input  1  serial data in; sampled at the rising edge of Clk.
- Q  output  WIDTH  parallel register contents, driven directly from flops with no combinational path.

Behaviour:
- Reset:
  - On the falling edge of RST, Q becomes RESET_VALUE without waiting for Clk.
  - While RST=0, Q holds RESET_VALUE regardless of Clk or SER.
- Normal operation (RST=1), every rising Clk edge:
  - MSB_FIRST_IN=0: Q_next = {Q[WIDTH-2:0], SER}.
  - MSB_FIRST_IN=1: Q_next = {SER, Q[WIDTH-1:1]}.
- Bit leaving the far end is discarded; there is no serial-out port.
- Latency:
  - A SER value sampled at edge n appears at the entry bit immediately after edge n.
  - It reaches the far end after WIDTH edges, then falls off on edge WIDTH+1.
- Fill: after WIDTH edges with constant SER=s from reset, Q = all s. With SER=1 and WIDTH=8, Q=8'hFF.
- Reset released coincident with a Clk edge: that edge performs no shift. The first shift occurs on the first rising edge at which RST is already 1.
- Reset asserted mid-stream: Q clears immediately and prior contents are lost; shifting resumes from RESET_VALUE after release.
- X or Z on SER is propagated into Q unchanged; no masking.
- No other state. Q must never change except on a rising Clk edge or on RST assertion.

Decomposition:
- Shared package holds:
  - SHREG_DEFAULT_WIDTH = 8.
  - Default reset-value constant.
- A typedef for the WIDTH-bit data word.
- Natural sub-module: dff_ar, a 1-bit flop with asynchronous active-low reset and a reset-value parameter.
- The top instantiates WIDTH dff_ar cells in a generate loop. Chaining direction is selected by MSB_FIRST_IN.
- Alternatively, a single always block is acceptable; the behaviour above is binding either way.

Test Plan:
- Reset held: RST=0, SER=1, Clk toggling with 20 ns period for 200 ns -> Q stays 8'h00 throughout.
- Fill with ones: release RST, SER=1 -> after edges 1..8, Q = 01, 03, 07, 0F, 1F, 3F, 7F, FF, then remains FF.
- Pattern shift: from reset, drive SER 1,0,1,1,0,0,1,0 on successive edges -> Q = 8'hB2 after the 8th edge. Two more edges with SER=0 give 8'hC8.
- Asynchronous reset mid-operation:
  - With Q=8'hFF, pull RST low between clock edges -> Q=8'h00 before the next Clk edge.
  - Release, then one edge with SER=1 -> Q=8'h01.
- Reset release on a Clk edge: RST rises coincident with a rising Clk, SER=1 -> Q=8'h00 after that edge and 8'h01 after the following edge.
- Parameter variant: WIDTH=4, MSB_FIRST_IN=1, SER=1,0,0,0 -> Q = 8, 4, 2, 1 (hex) on successive edges.
